// File: rtl/gnn_sched_pkg.sv
// rtl/gnn_sched_pkg.sv - shared types and constants for the GNN aggregation scheduler
package gnn_sched_pkg;

    localparam int BATCH_W_DEF  = 8;
    localparam int LAYER_W_DEF  = 4;
    localparam int WDOG_CYC_DEF = 16;

    // Aggregator datapath widths (features in, aggregated result out)
    localparam int AGG_FEAT_W = 5;
    localparam int AGG_RES_W  = 21;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_AGG      = 3'd2,
        ST_WAIT_AGG = 3'd3,
        ST_COMB     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/sched_wdog.sv
// rtl/sched_wdog.sv - cycle watchdog for the scheduler wait states
module sched_wdog
    import gnn_sched_pkg::*;
#(
    parameter int WDOG_CYC = WDOG_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(WDOG_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_eff;

    // clear marks the first cycle of a state, so that cycle counts as zero
    always_comb begin
        cnt_eff = clear ? '0 : cnt_q;
        expire  = enable && (cnt_eff == CNT_W'(WDOG_CYC - 1));
        cnt_d   = enable ? cnt_eff + CNT_W'(1) : '0;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gnn_agg_sched.sv
// rtl/gnn_agg_sched.sv - layer/batch scheduler for a GNN aggregator; SCHED_WDOG_EN adds a wait watchdog
module gnn_agg_sched
    import gnn_sched_pkg::*;
#(
    parameter int BATCH_W  = BATCH_W_DEF,
    parameter int LAYER_W  = LAYER_W_DEF,
    parameter int WDOG_CYC = WDOG_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [BATCH_W-1:0] num_batches,
    input  logic [LAYER_W-1:0] num_layers,
    output logic               feat_req,
    input  logic               feat_vld,
    output logic               agg_in_rdy,
    input  logic               agg_out_rdy,
    output logic               res_cap,
    output logic               comb_vld,
    input  logic               comb_rdy,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [BATCH_W-1:0] batch_idx,
    output logic [LAYER_W-1:0] layer_idx
);

    state_e             state_q, state_d;
    logic [BATCH_W-1:0] batch_q, batch_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic [BATCH_W-1:0] nb_q, nb_d;
    logic [LAYER_W-1:0] nl_q, nl_d;
    logic               settle_q, settle_d;
    logic               wdog_exp;
    logic               run_ok;

`ifdef SCHED_WDOG_EN
    logic entry_q, entry_d;
    logic err_q, err_d;

    sched_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (entry_q),
        .enable ((state_q == ST_WAIT_AGG) || (state_q == ST_COMB)),
        .expire (wdog_exp)
    );

    // entry flag and sticky error, cleared by an accepted start
    always_comb begin
        entry_d = (state_d != state_q);
        err_d   = err_q;
        if (!abort && state_q == ST_IDLE && start) begin
            err_d = 1'b0;
        end
        if (!abort && wdog_exp) begin
            err_d = 1'b1;
        end
    end

    // watchdog bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            entry_q <= entry_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wdog_exp = 1'b0;
    assign err      = 1'b0;
`endif

    // state and index registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            batch_q  <= '0;
            layer_q  <= '0;
            nb_q     <= '0;
            nl_q     <= '0;
            settle_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            batch_q  <= batch_d;
            layer_q  <= layer_d;
            nb_q     <= nb_d;
            nl_q     <= nl_d;
            settle_q <= settle_d;
        end
    end

    // next-state and index update; abort beats everything, then watchdog expiry
    always_comb begin
        state_d  = state_q;
        batch_d  = batch_q;
        layer_d  = layer_q;
        nb_d     = nb_q;
        nl_d     = nl_q;
        settle_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (wdog_exp) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        nb_d    = num_batches;
                        nl_d    = num_layers;
                        batch_d = '0;
                        layer_d = '0;
                        if (num_batches == '0 || num_layers == '0) begin
                            // empty run holds one settle cycle in DONE before pulsing
                            state_d  = ST_DONE;
                            settle_d = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (feat_vld) begin
                        state_d = ST_AGG;
                    end
                end
                ST_AGG: begin
                    state_d = ST_WAIT_AGG;
                end
                ST_WAIT_AGG: begin
                    if (agg_out_rdy) begin
                        state_d = ST_COMB;
                    end
                end
                ST_COMB: begin
                    if (comb_rdy) begin
                        if (batch_q != nb_q - BATCH_W'(1)) begin
                            batch_d = batch_q + BATCH_W'(1);
                            state_d = ST_FETCH;
                        end else if (layer_q != nl_q - LAYER_W'(1)) begin
                            batch_d = '0;
                            layer_d = layer_q + LAYER_W'(1);
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = settle_q ? ST_DONE : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // strobes decoded from state, silenced in reset, abort or expiry cycles
    always_comb begin
        run_ok     = rst_n && !abort && !wdog_exp;
        feat_req   = run_ok && (state_q == ST_FETCH);
        agg_in_rdy = run_ok && (state_q == ST_AGG);
        res_cap    = run_ok && (state_q == ST_WAIT_AGG) && agg_out_rdy;
        comb_vld   = run_ok && (state_q == ST_COMB);
        done       = run_ok && (state_q == ST_DONE) && !settle_q;
        busy       = rst_n && (state_q != ST_IDLE);
        batch_idx  = batch_q;
        layer_idx  = layer_q;
    end

endmodule
